// File: rtl/axil_reg_slave_if.sv
// ----------------------------------------------------------------------------
// axil_reg_slave_if
// Purpose : AXI4-Lite bus bundle between a master (VIP / MicroBlaze / bench)
//           and the axil_reg_slave register block.
// Params  : ADDR_WIDTH - byte address width (must match the slave's
//           C_S_AXI_ADDR_WIDTH); data is fixed at 32 bits, strobes at 4.
// Signals : AW / W / B write channels, AR / R read channels, each with the
//           usual VALID/READY handshake. PROT fields are carried but unused.
// Modports: master - drives addresses, data, VALIDs and B/R READYs
//           slave  - drives AW/W/AR READYs and the B/R response channels
// ----------------------------------------------------------------------------
interface axil_reg_slave_if #(
   parameter int ADDR_WIDTH = 6
);
   logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
   logic [2:0]            S_AXI_AWPROT;
   logic                  S_AXI_AWVALID;
   logic                  S_AXI_AWREADY;
   logic [31:0]           S_AXI_WDATA;
   logic [3:0]            S_AXI_WSTRB;
   logic                  S_AXI_WVALID;
   logic                  S_AXI_WREADY;
   logic [1:0]            S_AXI_BRESP;
   logic                  S_AXI_BVALID;
   logic                  S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
   logic [2:0]            S_AXI_ARPROT;
   logic                  S_AXI_ARVALID;
   logic                  S_AXI_ARREADY;
   logic [31:0]           S_AXI_RDATA;
   logic [1:0]            S_AXI_RRESP;
   logic                  S_AXI_RVALID;
   logic                  S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );
endinterface

// File: rtl/axil_reg_slave.sv
// ----------------------------------------------------------------------------
// axil_reg_slave
// Purpose : AXI4-Lite slave holding four 32-bit registers for the custom-IP
//           datapath, with the register contents exported as a flat bus.
//           One outstanding write and one outstanding read; the write and
//           read sides run independently.
// Ports   : S_AXI_ACLK    - clock
//           S_AXI_ARESETN - asynchronous reset, active-low
//           s_axi         - AXI4-Lite bus (axil_reg_slave_if.slave)
//           regs_o        - {reg3, reg2, reg1, reg0}, straight from the flops
// Decode  : addr[3:2] selects the register, addr[1:0] is ignored, any set
//           bit above bit 3 is out of range (SLVERR, no write, RDATA = 0).
// Options : MULADD_EN - when defined, reg3 is read-only and tracks
//           reg0*reg1 + reg2 (low 32 bits), refreshed on the edge after each
//           committed write; writes to reg3 answer OKAY and are dropped.
//           When undefined reg3 is an ordinary register and no multiplier
//           exists.
// ----------------------------------------------------------------------------
module axil_reg_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   axil_reg_slave_if.slave                 s_axi,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o
);

   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;

   localparam logic [0:0] WR_IDLE = 1'b0;
   localparam logic [0:0] WR_RESP = 1'b1;
   localparam logic [0:0] RD_IDLE = 1'b0;
   localparam logic [0:0] RD_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // write side state
   logic [0:0]    wrState_q, wrState_d;
   logic          awLatched_q, awLatched_d;
   logic          wLatched_q, wLatched_d;
   logic [AW-3:0] awAddr_q, awAddr_d;
   logic [DW-1:0] wData_q, wData_d;
   logic [3:0]    wStrb_q, wStrb_d;
   logic          awReady_q, awReady_d;
   logic          wReady_q, wReady_d;
   logic          bValid_q, bValid_d;
   logic [1:0]    bResp_q, bResp_d;
   logic          commit;

   // read side state
   logic [0:0]    rdState_q, rdState_d;
   logic          arPending_q, arPending_d;
   logic [AW-3:0] arAddr_q, arAddr_d;
   logic          arReady_q, arReady_d;
   logic          rValid_q, rValid_d;
   logic [DW-1:0] rData_q, rData_d;
   logic [1:0]    rResp_q, rResp_d;

   // register file
   logic [DW-1:0] regs_q [4];
   logic [DW-1:0] regs_d [4];
   logic          writeEn;

   logic          awOutOfRange, arOutOfRange;
   logic [1:0]    awIndex, arIndex;
   logic          unusedProt;

`ifdef MULADD_EN
   logic          recompute_q;
   logic [DW-1:0] mulAdd;
`endif

   // Addresses are kept as word addresses; anything above the two index bits
   // must be zero for the access to land inside the register file.
   assign awIndex      = awAddr_q[1:0];
   assign arIndex      = arAddr_q[1:0];
   assign awOutOfRange = (awAddr_q >> 2) != '0;
   assign arOutOfRange = (arAddr_q >> 2) != '0;
   assign unusedProt   = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

`ifdef MULADD_EN
   assign mulAdd = regs_q[0] * regs_q[1] + regs_q[2];
`endif

   // Write FSM. AW and W are captured independently on their own
   // handshakes; once both are held the next edge commits the write and
   // raises BVALID. The READYs are registered and derived from the next
   // state so they are low in reset and rise on the first edge after it.
   always_comb begin
      wrState_d   = wrState_q;
      awLatched_d = awLatched_q;
      wLatched_d  = wLatched_q;
      awAddr_d    = awAddr_q;
      wData_d     = wData_q;
      wStrb_d     = wStrb_q;
      bValid_d    = bValid_q;
      bResp_d     = bResp_q;
      commit      = 1'b0;
      case (wrState_q)
         WR_IDLE: begin
            if (awLatched_q && wLatched_q) begin
               commit      = 1'b1;
               bValid_d    = 1'b1;
               bResp_d     = awOutOfRange ? RESP_SLVERR : RESP_OKAY;
               awLatched_d = 1'b0;
               wLatched_d  = 1'b0;
               wrState_d   = WR_RESP;
            end else begin
               if (s_axi.S_AXI_AWVALID && awReady_q) begin
                  awLatched_d = 1'b1;
                  awAddr_d    = s_axi.S_AXI_AWADDR[AW-1:2];
               end
               if (s_axi.S_AXI_WVALID && wReady_q) begin
                  wLatched_d = 1'b1;
                  wData_d    = s_axi.S_AXI_WDATA;
                  wStrb_d    = s_axi.S_AXI_WSTRB;
               end
            end
         end
         WR_RESP: begin
            if (s_axi.S_AXI_BREADY) begin
               bValid_d  = 1'b0;
               bResp_d   = RESP_OKAY;
               wrState_d = WR_IDLE;
            end
         end
         default: wrState_d = WR_IDLE;
      endcase
      awReady_d = (wrState_d == WR_IDLE) && !awLatched_d;
      wReady_d  = (wrState_d == WR_IDLE) && !wLatched_d;
   end

   // Register file update. Writes merge per byte lane under the latched
   // strobes. With the multiply-add option reg3 is never written from the
   // bus and is instead refreshed one edge after any commit.
   always_comb begin
`ifdef MULADD_EN
      writeEn = commit && !awOutOfRange && (awIndex != 2'd3);
`else
      writeEn = commit && !awOutOfRange;
`endif
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end
      for (int b = 0; b < 4; b++) begin
         if (writeEn && wStrb_q[b]) begin
            regs_d[awIndex][8*b +: 8] = wData_q[8*b +: 8];
         end
      end
`ifdef MULADD_EN
      if (recompute_q) begin
         regs_d[3] = mulAdd;
      end
`endif
   end

   // Read FSM. An AR handshake parks the address for one cycle, then the
   // register is sampled into RDATA. Sampling regs_q (not regs_d) means a
   // write committing on the same edge is not yet visible to the read.
   always_comb begin
      rdState_d   = rdState_q;
      arPending_d = arPending_q;
      arAddr_d    = arAddr_q;
      rValid_d    = rValid_q;
      rData_d     = rData_q;
      rResp_d     = rResp_q;
      case (rdState_q)
         RD_IDLE: begin
            if (arPending_q) begin
               arPending_d = 1'b0;
               rValid_d    = 1'b1;
               rData_d     = arOutOfRange ? '0 : regs_q[arIndex];
               rResp_d     = arOutOfRange ? RESP_SLVERR : RESP_OKAY;
               rdState_d   = RD_DATA;
            end else if (s_axi.S_AXI_ARVALID && arReady_q) begin
               arPending_d = 1'b1;
               arAddr_d    = s_axi.S_AXI_ARADDR[AW-1:2];
            end
         end
         RD_DATA: begin
            if (s_axi.S_AXI_RREADY) begin
               rValid_d  = 1'b0;
               rData_d   = '0;
               rResp_d   = RESP_OKAY;
               rdState_d = RD_IDLE;
            end
         end
         default: rdState_d = RD_IDLE;
      endcase
      arReady_d = (rdState_d == RD_IDLE) && !arPending_d;
   end

   // All state flops. Reset aborts any transaction in flight: VALIDs drop
   // at once, latched beats are forgotten and the registers clear.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wrState_q   <= WR_IDLE;
         awLatched_q <= 1'b0;
         wLatched_q  <= 1'b0;
         awAddr_q    <= '0;
         wData_q     <= '0;
         wStrb_q     <= '0;
         awReady_q   <= 1'b0;
         wReady_q    <= 1'b0;
         bValid_q    <= 1'b0;
         bResp_q     <= RESP_OKAY;
         rdState_q   <= RD_IDLE;
         arPending_q <= 1'b0;
         arAddr_q    <= '0;
         arReady_q   <= 1'b0;
         rValid_q    <= 1'b0;
         rData_q     <= '0;
         rResp_q     <= RESP_OKAY;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
`ifdef MULADD_EN
         recompute_q <= 1'b0;
`endif
      end else begin
         wrState_q   <= wrState_d;
         awLatched_q <= awLatched_d;
         wLatched_q  <= wLatched_d;
         awAddr_q    <= awAddr_d;
         wData_q     <= wData_d;
         wStrb_q     <= wStrb_d;
         awReady_q   <= awReady_d;
         wReady_q    <= wReady_d;
         bValid_q    <= bValid_d;
         bResp_q     <= bResp_d;
         rdState_q   <= rdState_d;
         arPending_q <= arPending_d;
         arAddr_q    <= arAddr_d;
         arReady_q   <= arReady_d;
         rValid_q    <= rValid_d;
         rData_q     <= rData_d;
         rResp_q     <= rResp_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
`ifdef MULADD_EN
         recompute_q <= commit;
`endif
      end
   end

   assign s_axi.S_AXI_AWREADY = awReady_q;
   assign s_axi.S_AXI_WREADY  = wReady_q;
   assign s_axi.S_AXI_BVALID  = bValid_q;
   assign s_axi.S_AXI_BRESP   = bResp_q;
   assign s_axi.S_AXI_ARREADY = arReady_q;
   assign s_axi.S_AXI_RVALID  = rValid_q;
   assign s_axi.S_AXI_RDATA   = rData_q;
   assign s_axi.S_AXI_RRESP   = rResp_q;

   assign regs_o = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axil_reg_slave
// Purpose : directed self-checking bench for axil_reg_slave. Expected B and
//           R responses are queued when a transaction is launched and popped
//           when the slave answers; a small register model supplies the
//           expected contents. Build with +define+MULADD_EN to exercise the
//           multiply-add variant of reg3.
// ----------------------------------------------------------------------------
module tb_axil_reg_slave;

   logic         clk;
   logic         rst_n;
   logic [127:0] regsOut;

   int total = 0;
   int bad   = 0;

   logic [1:0]  bQ [$];
   logic [33:0] rQ [$];
   logic [31:0] model [4];

   axil_reg_slave_if #(.ADDR_WIDTH(6)) bus ();

   axil_reg_slave #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(6)
   ) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESETN(rst_n),
      .s_axi        (bus),
      .regs_o       (regsOut)
   );

   // 100 MHz free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference register behaviour: byte-lane merge, out-of-range ignored,
   // and in the multiply-add build reg3 follows reg0*reg1+reg2
   task automatic modelWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit allowed;
      allowed = (addr[5:4] == 2'b00);
`ifdef MULADD_EN
      if (addr[3:2] == 2'd3) allowed = 1'b0;
`endif
      for (int b = 0; b < 4; b++) begin
         if (allowed && strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
      end
`ifdef MULADD_EN
      model[3] = model[0] * model[1] + model[2];
`endif
   endtask

   function automatic logic [31:0] modelRead(input logic [5:0] addr);
      return (addr[5:4] != 2'b00) ? 32'h0 : model[addr[3:2]];
   endfunction

   function automatic logic [1:0] modelResp(input logic [5:0] addr);
      return (addr[5:4] != 2'b00) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [127:0] modelFlat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   // Full write transaction: W may lag AW by wDelay cycles and BREADY is
   // withheld for bDelay cycles once BVALID appears
   task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input int wDelay, input int bDelay, input string tag);
      int cyc;
      bit awDone, wDone, awHs, wHs;
      bQ.push_back(modelResp(addr));
      @(negedge clk);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = (wDelay == 0);
      cyc = 0; awDone = 0; wDone = 0;
      while (!(awDone && wDone) && cyc < 30) begin
         awHs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         wHs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         @(negedge clk);
         cyc++;
         if (awHs) begin awDone = 1; bus.S_AXI_AWVALID = 1'b0; end
         if (wHs)  begin wDone = 1;  bus.S_AXI_WVALID  = 1'b0; end
         if (!wDone && cyc >= wDelay) bus.S_AXI_WVALID = 1'b1;
         if (awDone && !wDone) checkOutput({tag, " awready while W pending"}, bus.S_AXI_AWREADY, 1'b0);
      end
      cyc = 0;
      while (!bus.S_AXI_BVALID && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, " bvalid"}, bus.S_AXI_BVALID, 1'b1);
      for (int i = 0; i < bDelay; i++) begin
         @(negedge clk);
         checkOutput({tag, " bvalid held"}, bus.S_AXI_BVALID, 1'b1);
         checkOutput({tag, " awready in resp"}, bus.S_AXI_AWREADY, 1'b0);
         checkOutput({tag, " wready in resp"}, bus.S_AXI_WREADY, 1'b0);
      end
      bus.S_AXI_BREADY = 1'b1;
      if (bQ.size() > 0) checkOutput({tag, " bresp"}, bus.S_AXI_BRESP, bQ.pop_front());
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      checkOutput({tag, " bvalid cleared"}, bus.S_AXI_BVALID, 1'b0);
   endtask

   // Full read transaction with exact AR-to-RVALID latency and an RREADY
   // stall of rDelay cycles
   task automatic doRead(input logic [5:0] addr, input logic [31:0] expData, input logic [1:0] expResp,
                         input int rDelay, input string tag);
      int cyc;
      logic [33:0] exp;
      rQ.push_back({expResp, expData});
      @(negedge clk);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      cyc = 0;
      while (!bus.S_AXI_ARREADY && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, " arready"}, bus.S_AXI_ARREADY, 1'b1);
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      checkOutput({tag, " rvalid one cycle after AR"}, bus.S_AXI_RVALID, 1'b0);
      @(negedge clk);
      checkOutput({tag, " rvalid two cycles after AR"}, bus.S_AXI_RVALID, 1'b1);
      for (int i = 0; i < rDelay; i++) begin
         @(negedge clk);
         checkOutput({tag, " rvalid held"}, bus.S_AXI_RVALID, 1'b1);
         checkOutput({tag, " rdata held"}, bus.S_AXI_RDATA, expData);
         checkOutput({tag, " arready in data"}, bus.S_AXI_ARREADY, 1'b0);
      end
      bus.S_AXI_RREADY = 1'b1;
      if (rQ.size() > 0) begin
         exp = rQ.pop_front();
         checkOutput({tag, " rdata"}, bus.S_AXI_RDATA, exp[31:0]);
         checkOutput({tag, " rresp"}, bus.S_AXI_RRESP, exp[33:32]);
      end
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      checkOutput({tag, " rvalid cleared"}, bus.S_AXI_RVALID, 1'b0);
   endtask

   // Directed sequence covering reset, basic access, handshake ordering,
   // strobes, decode errors, same-edge collision, the optional multiply-add
   // register and reset in the middle of traffic
   initial begin
      int cyc;
      rst_n = 1'b0;
      bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;

      // reset state
      #3;
      checkOutput("reset awready", bus.S_AXI_AWREADY, 1'b0);
      checkOutput("reset arready", bus.S_AXI_ARREADY, 1'b0);
      checkOutput("reset bvalid", bus.S_AXI_BVALID, 1'b0);
      checkOutput("reset rvalid", bus.S_AXI_RVALID, 1'b0);
      checkOutput("reset rdata", bus.S_AXI_RDATA, 32'h0);
      checkOutput("reset regs", regsOut, 128'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("ready before first edge", bus.S_AXI_WREADY, 1'b0);
      @(negedge clk);
      checkOutput("awready after first edge", bus.S_AXI_AWREADY, 1'b1);
      checkOutput("wready after first edge", bus.S_AXI_WREADY, 1'b1);
      checkOutput("arready after first edge", bus.S_AXI_ARREADY, 1'b1);

      // four plain writes and read-back
      for (int i = 0; i < 4; i++) begin
         applyStimulus(6'(4 * i), 32'(i + 1), 4'hF, 0, 0, "basic write");
         modelWrite(6'(4 * i), 32'(i + 1), 4'hF);
      end
      for (int i = 0; i < 4; i++) begin
         doRead(6'(4 * i), modelRead(6'(4 * i)), 2'b00, i, "basic read");
      end
`ifdef MULADD_EN
      checkOutput("basic regs_o", regsOut, 128'h00000005_00000003_00000002_00000001);
`else
      checkOutput("basic regs_o", regsOut, 128'h00000004_00000003_00000002_00000001);
`endif

      // AW two cycles ahead of W, BREADY withheld five cycles
      applyStimulus(6'h08, 32'hDEADBEEF, 4'hF, 2, 5, "late W");
      modelWrite(6'h08, 32'hDEADBEEF, 4'hF);
      checkOutput("late W regs_o", regsOut, modelFlat());
      doRead(6'h08, 32'hDEADBEEF, 2'b00, 0, "late W read");

      // single byte lane strobe
      applyStimulus(6'h00, 32'h00000001, 4'hF, 0, 0, "strobe base");
      modelWrite(6'h00, 32'h00000001, 4'hF);
      applyStimulus(6'h00, 32'hAABBCCDD, 4'b0010, 0, 1, "strobe lane1");
      modelWrite(6'h00, 32'hAABBCCDD, 4'b0010);
      doRead(6'h00, 32'h0000CC01, 2'b00, 0, "strobe read");

      // out-of-range write and read; low address bits ignored
      applyStimulus(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, "oor write");
      checkOutput("oor regs unchanged", regsOut, modelFlat());
      doRead(6'h10, 32'h0, 2'b10, 0, "oor read");
      doRead(6'h06, modelRead(6'h04), 2'b00, 0, "unaligned read");

      // write and read of reg1 committing on the same edge: old value returns
      fork
         applyStimulus(6'h04, 32'h12345678, 4'hF, 0, 0, "collide write");
         doRead(6'h04, modelRead(6'h04), 2'b00, 0, "collide read");
      join
      modelWrite(6'h04, 32'h12345678, 4'hF);
      doRead(6'h04, 32'h12345678, 2'b00, 0, "after collide read");

`ifdef MULADD_EN
      // reg3 = reg0*reg1 + reg2, read-only
      applyStimulus(6'h00, 32'd3, 4'hF, 0, 0, "muladd r0");
      applyStimulus(6'h04, 32'd5, 4'hF, 0, 0, "muladd r1");
      applyStimulus(6'h08, 32'd7, 4'hF, 0, 0, "muladd r2");
      modelWrite(6'h00, 32'd3, 4'hF);
      modelWrite(6'h04, 32'd5, 4'hF);
      modelWrite(6'h08, 32'd7, 4'hF);
      doRead(6'h0C, 32'd22, 2'b00, 0, "muladd read");
      applyStimulus(6'h0C, 32'd9, 4'hF, 0, 0, "muladd write r3");
      doRead(6'h0C, 32'd22, 2'b00, 0, "muladd read again");
`endif

      // reset while a B response and an R response are both pending
      @(negedge clk);
      bus.S_AXI_AWADDR  = 6'h00; bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1;  bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_ARADDR  = 6'h04; bus.S_AXI_ARVALID = 1'b1;
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
      cyc = 0;
      while (!(bus.S_AXI_BVALID && bus.S_AXI_RVALID) && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("abort bvalid pending", bus.S_AXI_BVALID, 1'b1);
      checkOutput("abort rvalid pending", bus.S_AXI_RVALID, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort bvalid dropped", bus.S_AXI_BVALID, 1'b0);
      checkOutput("abort rvalid dropped", bus.S_AXI_RVALID, 1'b0);
      checkOutput("abort regs cleared", regsOut, 128'h0);
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort awready held low", bus.S_AXI_AWREADY, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("abort no stale bvalid", bus.S_AXI_BVALID, 1'b0);
      checkOutput("abort awready back", bus.S_AXI_AWREADY, 1'b1);
      for (int i = 0; i < 4; i++) begin
         doRead(6'(4 * i), 32'h0, 2'b00, 0, "post-reset read");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a handshake never completes
   initial begin
      #200000;
      bad++;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
